fs_backing_store: RTL and testbench

//   On-chip backing store that services the page-swap port of the paged RAM (fsRden/fsWren/fsMeta/

---
 rtl/fs_backing_store.sv | 166 ++++++++++++++++
 tb/tb_fs_backing_store.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fs_backing_store.sv
// fs_backing_store: on-chip backing store behind the pager's page-swap port.
// Holds evicted page data and per-page permission metadata. Both arrays read
// in one cycle, and a read on the same edge as a write returns the old value.
// After reset an init sweep loads DEFAULT_PERMS into every metadata entry,
// then ready is raised.
// Optional feature macro: FS_STATS_EN builds the fault/page-in/page-out
// counters. When it is undefined, the three counter ports are tied to zero.
module fs_backing_store #(
    parameter int         DATA_AW       = 14,
    parameter int         META_AW       = 8,
    parameter logic [3:0] DEFAULT_PERMS = 4'b0110
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fsAccess,
    input  logic        fsRden,
    input  logic        fsWren,
    input  logic        fsMeta,
    input  logic [31:0] fsAddress,
    input  logic [31:0] fsData,
    output logic [31:0] fsQ,
    output logic        ready,
    output logic        oob_err,
    input  logic        err_clr,
    output logic [15:0] fault_cnt,
    output logic [15:0] pagein_cnt,
    output logic [15:0] pageout_cnt
);

    localparam int DATA_W = 32;
    localparam int META_W = 4;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t             state;
    logic [META_AW-1:0] sweep_idx;

    logic [DATA_W-1:0]  data_mem [2**DATA_AW];
    logic [META_W-1:0]  meta_mem [2**META_AW];

    logic               in_idle;
    logic               req;
    logic               addr_oob;
    logic               acc_ok;
    logic               err_ev;
    logic [DATA_AW-1:0] data_idx;
    logic [META_AW-1:0] meta_idx;

    // Address decode: each array has its own range check on the upper address bits.
    assign in_idle  = (state == ST_IDLE);
    assign req      = fsRden | fsWren;
    assign addr_oob = fsMeta ? (|fsAddress[31:META_AW]) : (|fsAddress[31:DATA_AW]);
    assign acc_ok   = in_idle & ~addr_oob;
    assign err_ev   = req & (~in_idle | addr_oob);
    assign data_idx = fsAddress[DATA_AW-1:0];
    assign meta_idx = fsAddress[META_AW-1:0];

    // Init sweep sequencer: one metadata entry per cycle, then IDLE until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (sweep_idx == {META_AW{1'b1}}) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Metadata array: the sweep owns the write port until IDLE, then the swap port does.
    always_ff @(posedge clk) begin
        if (!in_idle) begin
            meta_mem[sweep_idx] <= DEFAULT_PERMS;
        end else if (fsWren && fsMeta && acc_ok) begin
            meta_mem[meta_idx] <= fsData[META_W-1:0];
        end
    end

    // Data array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (fsWren && !fsMeta && acc_ok) begin
            data_mem[data_idx] <= fsData;
        end
    end

    // Registered read port: old contents on a same-edge write, zero on a rejected read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsQ <= '0;
        end else if (fsRden) begin
            if (!acc_ok) begin
                fsQ <= '0;
            end else if (fsMeta) begin
                fsQ <= {{(DATA_W-META_W){1'b0}}, meta_mem[meta_idx]};
            end else begin
                fsQ <= data_mem[data_idx];
            end
        end
    end

    // Sticky error flag: a new error on the same edge wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_err <= 1'b0;
        end else if (err_ev) begin
            oob_err <= 1'b1;
        end else if (err_clr) begin
            oob_err <= 1'b0;
        end
    end

`ifdef FS_STATS_EN
    logic        acc_q;
    logic [15:0] fault_q;
    logic [15:0] pagein_q;
    logic [15:0] pageout_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Swap statistics: counters saturate and count only accepted IDLE activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= 1'b0;
            fault_q   <= '0;
            pagein_q  <= '0;
            pageout_q <= '0;
        end else begin
            acc_q <= fsAccess;
            if (in_idle && fsAccess && !acc_q) begin
                fault_q <= sat_inc(fault_q);
            end
            if (acc_ok && fsMeta && fsRden) begin
                pagein_q <= sat_inc(pagein_q);
            end
            if (acc_ok && fsMeta && fsWren) begin
                pageout_q <= sat_inc(pageout_q);
            end
        end
    end

    assign fault_cnt   = fault_q;
    assign pagein_cnt  = pagein_q;
    assign pageout_cnt = pageout_q;
`else
    logic unused_stats;
    assign unused_stats = fsAccess;
    assign fault_cnt    = 16'h0000;
    assign pagein_cnt   = 16'h0000;
    assign pageout_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_fs_backing_store.sv
// Bench for fs_backing_store: randomized swap-port traffic against an array-level
// model, with a queue-based scoreboard for fsQ and direct checks of ready/oob_err/counters.
module tb_fs_backing_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fsAccess, fsRden, fsWren, fsMeta, err_clr;
    logic [31:0] fsAddress, fsData;
    logic [31:0] fsQ;
    logic        ready, oob_err;
    logic [15:0] fault_cnt, pagein_cnt, pageout_cnt;

    always #5 clk = ~clk;

    fs_backing_store dut (
        .clk(clk), .rst_n(rst_n), .fsAccess(fsAccess), .fsRden(fsRden), .fsWren(fsWren),
        .fsMeta(fsMeta), .fsAddress(fsAddress), .fsData(fsData), .fsQ(fsQ), .ready(ready),
        .oob_err(oob_err), .err_clr(err_clr), .fault_cnt(fault_cnt),
        .pagein_cnt(pagein_cnt), .pageout_cnt(pageout_cnt)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] data_m [int];
    logic [3:0]  meta_m [256];
    int          written[$];
    logic        exp_err;
    logic        m_ready;
    logic [31:0] last_q;
    int          m_fault, m_pin, m_pout;
    logic        mon_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) meta_m[i] = 4'h6;
        exp_err = 1'b0;
        m_ready = 1'b0;
        last_q  = 32'h0;
        m_fault = 0;
        m_pin   = 0;
        m_pout  = 0;
    endtask

    // Monitor: a read strobe sampled on an edge must show its result just after that edge.
    initial begin
        forever begin
            @(posedge clk);
            mon_rd = fsRden;
            #1;
            if (mon_rd === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL fsQ_unexpected: got 0x%08h expected no read", fsQ);
                end else begin
                    chk("fsQ", fsQ, exp_q.pop_front());
                end
            end
        end
    end

    // One swap-port transaction held for one edge; the model is updated from the rules.
    task automatic access(input logic rd, input logic wr, input logic mt,
                          input logic [31:0] a, input logic [31:0] d, input logic clr);
        logic        oob;
        logic [31:0] e;
        oob = mt ? (a >= 32'd256) : (a >= 32'd16384);
        if (rd) begin
            if (!m_ready || oob) e = 32'h0;
            else if (mt)         e = {28'h0, meta_m[a[7:0]]};
            else                 e = data_m[int'(a)];
            exp_q.push_back(e);
            last_q = e;
        end
        if (wr && m_ready && !oob) begin
            if (mt) meta_m[a[7:0]] = d[3:0];
            else begin
                if (!data_m.exists(int'(a))) written.push_back(int'(a));
                data_m[int'(a)] = d;
            end
        end
        if (m_ready && !oob && mt) begin
            if (rd) m_pin++;
            if (wr) m_pout++;
        end
        if ((rd || wr) && (!m_ready || oob)) exp_err = 1'b1;
        else if (clr)                        exp_err = 1'b0;
        fsRden = rd; fsWren = wr; fsMeta = mt; fsAddress = a; fsData = d; err_clr = clr;
        @(posedge clk); #1;
        fsRden = 1'b0; fsWren = 1'b0; err_clr = 1'b0;
        chk("oob_err", {31'h0, oob_err}, {31'h0, exp_err});
    endtask

    task automatic idle_chk();
        @(posedge clk); #1;
        chk("fsQ_hold", fsQ, last_q);
    endtask

    task automatic pulse_access();
        fsAccess = 1'b1;
        @(posedge clk); #1;
        fsAccess = 1'b0;
        @(posedge clk); #1;
        if (m_ready) m_fault++;
    endtask

    // Counts edges after reset release until ready; optionally pokes the port mid-sweep.
    task automatic sweep(input int poke, input int stop, output int n);
        n = 0;
        forever begin
            @(posedge clk); #1;
            n++;
            fsRden = 1'b0; fsWren = 1'b0;
            if (ready || n > 400 || n == stop) break;
            if (n == poke) begin
                fsRden = 1'b1; fsWren = 1'b1; fsMeta = 1'b1;
                fsAddress = 32'h3; fsData = 32'hF;
                exp_q.push_back(32'h0);
                exp_err = 1'b1;
            end
        end
        m_ready = (stop <= 0);
    endtask

    task automatic chk_counters(input int f, input int pin, input int pout);
`ifdef FS_STATS_EN
        chk("fault_cnt",   {16'h0, fault_cnt},   f);
        chk("pagein_cnt",  {16'h0, pagein_cnt},  pin);
        chk("pageout_cnt", {16'h0, pageout_cnt}, pout);
`else
        chk("fault_cnt_tied",   {16'h0, fault_cnt},   (f * 0));
        chk("pagein_cnt_tied",  {16'h0, pagein_cnt},  (pin * 0));
        chk("pageout_cnt_tied", {16'h0, pageout_cnt}, (pout * 0));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int a;
        logic clr;
        rst_n = 1'b0; fsAccess = 1'b0; fsRden = 1'b0; fsWren = 1'b0; fsMeta = 1'b0;
        err_clr = 1'b0; fsAddress = '0; fsData = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_fsQ", fsQ, 32'h0);
        chk("rst_oob_err", {31'h0, oob_err}, 32'h0);
        chk_counters(m_fault, m_pin, m_pout);

        // Sweep length, with an access during INIT that must be rejected.
        rst_n = 1'b1;
        sweep(10, 0, n);
        chk("ready_cycles", n, 256);
        chk("init_access_err", {31'h0, oob_err}, {31'h0, exp_err});
        access(1'b1, 1'b0, 1'b1, 32'h5, 32'h0, 1'b1);
        access(1'b1, 1'b0, 1'b1, 32'h3, 32'h0, 1'b0);

        // Data write then read back; same-edge read-first.
        access(1'b0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0);
        access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
        idle_chk();
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h1, 1'b0);
        access(1'b1, 1'b1, 1'b0, 32'h10, 32'h2, 1'b0);
        access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);

        // Out-of-range accesses, clear, and set-wins-over-clear.
        access(1'b1, 1'b0, 1'b0, 32'h00010000, 32'h0, 1'b0);
        access(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        access(1'b0, 1'b1, 1'b1, 32'h100, 32'h9, 1'b1);
        access(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
        access(1'b0, 1'b1, 1'b0, 32'h00004000, 32'h12345678, 1'b0);
        access(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 250; i++) begin
            k   = $urandom_range(0, 10);
            clr = ($urandom_range(0, 3) == 0);
            case (k)
                0, 1: access(1'b0, 1'b1, 1'b0, $urandom_range(0, 16383), $urandom, clr);
                2, 3: begin
                    a = written[$urandom_range(0, written.size() - 1)];
                    access(1'b1, 1'b0, 1'b0, a, 32'h0, clr);
                end
                4: access(1'b0, 1'b1, 1'b1, $urandom_range(0, 255), $urandom, clr);
                5: access(1'b1, 1'b0, 1'b1, $urandom_range(0, 255), 32'h0, clr);
                6: begin
                    a = written[$urandom_range(0, written.size() - 1)];
                    access(1'b1, 1'b1, 1'b0, a, $urandom, clr);
                end
                7: access(1'b1, 1'b1, 1'b1, $urandom_range(0, 255), $urandom, clr);
                8: begin
                    if ($urandom_range(0, 1) == 0)
                        access($urandom_range(0, 1), 1'b1, 1'b0, $urandom | 32'h00010000, $urandom, clr);
                    else
                        access(1'b1, $urandom_range(0, 1), 1'b1, 32'h100 + $urandom_range(0, 5000), $urandom, clr);
                end
                9: pulse_access();
                default: idle_chk();
            endcase
        end
        idle_chk();
        chk_counters(m_fault, m_pin, m_pout);

        // Reset mid-sweep: the full sweep restarts and metadata returns to defaults.
        access(1'b0, 1'b1, 1'b1, 32'h7, 32'hA, 1'b0);
        access(1'b1, 1'b0, 1'b1, 32'h7, 32'h0, 1'b0);
        idle_chk();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst2_fsQ", fsQ, 32'h0);
        chk("rst2_ready", {31'h0, ready}, 32'h0);
        rst_n = 1'b1;
        sweep(0, 100, n);
        chk("partial_sweep_ready", {31'h0, ready}, 32'h0);
        rst_n = 1'b0;
        #2;
        chk("rst3_ready", {31'h0, ready}, 32'h0);
        rst_n = 1'b1;
        sweep(0, 0, n);
        chk("resweep_cycles", n, 256);
        access(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        access(1'b1, 1'b0, 1'b1, 32'h7, 32'h0, 1'b0);
        exp_q.push_back(32'hDEADBEEF);
        last_q = 32'hDEADBEEF;
        fsRden = 1'b1; fsMeta = 1'b0; fsAddress = 32'h40;
        @(posedge clk); #1;
        fsRden = 1'b0;

        // Statistics after a clean reset: 3 faults, 2 page-outs, 3 page-ins.
        chk_counters(0, 2, 0);
        pulse_access(); pulse_access(); pulse_access();
        access(1'b0, 1'b1, 1'b1, 32'h11, 32'h3, 1'b0);
        access(1'b0, 1'b1, 1'b1, 32'h12, 32'h5, 1'b0);
        access(1'b1, 1'b0, 1'b1, 32'h11, 32'h0, 1'b0);
        access(1'b1, 1'b0, 1'b1, 32'h12, 32'h0, 1'b0);
        access(1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 1'b0);
        idle_chk();
        chk_counters(3, 5, 2);
        chk_counters(m_fault, m_pin, m_pout);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
